// File: rtl/compress_handler.sv
`default_nettype none
// ============================================================================
// Module : compress_handler
// Run-length encoder: reads an MSB-first bit stream from RAM, emits {value,len}.
// Rev    : 1.0
// ============================================================================
module compress_handler #(
   parameter int MAX_RUN = 127,
   parameter int RD_LAT  = 1
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        start,
   input  logic [15:0] byteIndx,
   input  logic [2:0]  bitIndx,
   input  logic [31:0] num_bits,
   output logic [15:0] ramAddress,
   output logic        read_signal,
   input  logic [7:0]  ramDataOut,
   output logic [7:0]  code_out,
   output logic        code_valid,
   input  logic        code_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] code_count
);
   localparam int               CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);
   localparam logic [6:0]       RUN_MAX  = 7'(MAX_RUN);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SCAN  = 3'd2,
      EMIT  = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t           state;
   logic [15:0]      addr;
   logic [2:0]       bit_pos;
   logic [31:0]      bits_left;
   logic [7:0]       byte_reg;
   logic [6:0]       run_len;
   logic             cur_val;
   logic             last;
   logic [CNT_W-1:0] lat_cnt;

   logic        cur_bit;
   logic        take;
   logic [15:0] addr_next;
   logic [6:0]  run_inc;

   assign cur_bit   = byte_reg[bit_pos];
   assign take      = (run_len == 7'd0) || ((cur_bit == cur_val) && (run_len < RUN_MAX));
   assign addr_next = addr + 16'd1;
   assign run_inc   = run_len + 7'd1;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         addr        <= 16'd0;
         bit_pos     <= 3'd0;
         bits_left   <= 32'd0;
         byte_reg    <= 8'd0;
         run_len     <= 7'd0;
         cur_val     <= 1'b0;
         last        <= 1'b0;
         lat_cnt     <= '0;
         ramAddress  <= 16'd0;
         read_signal <= 1'b0;
         code_out    <= 8'd0;
         code_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         code_count  <= 16'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  code_count <= 16'd0;
                  run_len    <= 7'd0;
                  last       <= 1'b0;
                  if (num_bits == 32'd0) begin
                     state <= FIN;
                  end else begin
                     addr        <= byteIndx;
                     bit_pos     <= bitIndx;
                     bits_left   <= num_bits;
                     ramAddress  <= byteIndx;
                     read_signal <= 1'b1;
                     lat_cnt     <= '0;
                     state       <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (lat_cnt == LAT_LAST) begin
                  byte_reg    <= ramDataOut;
                  read_signal <= 1'b0;
                  state       <= SCAN;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end
            SCAN: begin
               if (take) begin
                  if (run_len == 7'd0)
                     cur_val <= cur_bit;
                  run_len   <= run_inc;
                  bits_left <= bits_left - 32'd1;
                  if (bit_pos == 3'd0) begin
                     bit_pos <= 3'd7;
                     addr    <= addr_next;
                  end else begin
                     bit_pos <= bit_pos - 3'd1;
                  end
                  // The final bit closes the run even if the byte is not finished.
                  if (bits_left == 32'd1) begin
                     code_out   <= {cur_bit, run_inc};
                     code_valid <= 1'b1;
                     last       <= 1'b1;
                     state      <= EMIT;
                  end else if (bit_pos == 3'd0) begin
                     ramAddress  <= addr_next;
                     read_signal <= 1'b1;
                     lat_cnt     <= '0;
                     state       <= FETCH;
                  end
               end else begin
                  code_out   <= {cur_val, run_len};
                  code_valid <= 1'b1;
                  last       <= 1'b0;
                  state      <= EMIT;
               end
            end
            EMIT: begin
               if (code_ready) begin
                  code_valid <= 1'b0;
                  code_count <= code_count + 16'd1;
                  run_len    <= 7'd0;
                  state      <= last ? FIN : SCAN;
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_compress_handler.sv
`default_nettype none
// ============================================================================
// Module : tb_compress_handler
// Scoreboard bench for compress_handler with a run-list reference model.
// Rev    : 1.0
// ============================================================================
module tb_compress_handler;
   localparam int MAX_RUN = 127;
   localparam int RD_LAT  = 1;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [15:0] byteIndx;
   logic [2:0]  bitIndx;
   logic [31:0] num_bits;
   logic [15:0] ramAddress;
   logic        read_signal;
   logic [7:0]  ramDataOut;
   logic [7:0]  code_out;
   logic        code_valid;
   logic        code_ready;
   logic        busy;
   logic        done;
   logic [15:0] code_count;

   logic [7:0]  mem [0:65535];
   logic [7:0]  exp_q[$];
   logic [15:0] rd_q[$];
   int          tests = 0;
   int          fails = 0;
   int          ready_mode = 0;

   always #5 clk = ~clk;
   assign ramDataOut = mem[ramAddress];

   compress_handler #(.MAX_RUN(MAX_RUN), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .RST(RST), .start(start), .byteIndx(byteIndx), .bitIndx(bitIndx),
      .num_bits(num_bits), .ramAddress(ramAddress), .read_signal(read_signal),
      .ramDataOut(ramDataOut), .code_out(code_out), .code_valid(code_valid),
      .code_ready(code_ready), .busy(busy), .done(done), .code_count(code_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk the source bits, cut a new code on a value change or a full run.
   task automatic model(input logic [15:0] a, input int bp, input int n, output int ncodes);
      int          run;
      logic        cv;
      logic        v;
      logic [15:0] ad;
      int          p;
      run = 0; cv = 1'b0; ad = a; p = bp; ncodes = 0;
      for (int i = 0; i < n; i++) begin
         v = mem[ad][p];
         if (run > 0 && (v != cv || run == MAX_RUN)) begin
            exp_q.push_back({cv, 7'(run)});
            ncodes++;
            run = 0;
         end
         if (run == 0) cv = v;
         run++;
         if (p == 0) begin p = 7; ad = ad + 16'd1; end
         else p--;
      end
      if (run > 0) begin
         exp_q.push_back({cv, 7'(run)});
         ncodes++;
      end
   endtask

   task automatic run_job(input logic [15:0] a, input logic [2:0] bp, input int n,
                          input int mode, input string tag);
      int ncodes, nbytes, bad;
      bit got;
      ready_mode = mode;
      model(a, int'(bp), n, ncodes);
      nbytes = (n == 0) ? 0 : ((7 - int'(bp)) + n + 7) / 8;
      rd_q.delete();
      @(posedge clk); #1;
      byteIndx = a; bitIndx = bp; num_bits = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " busy_after_start"}, busy, 1);
      if (n == 0) begin
         chk({tag, " done_not_early"}, done, 0);
         @(posedge clk); #1;
         chk({tag, " done_two_cycles"}, done, 1);
      end
      got = 0;
      for (int cyc = 0; cyc < 20000 && !got; cyc++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      chk({tag, " done_seen"}, got, 1);
      chk({tag, " codes_left"}, exp_q.size(), 0);
      chk({tag, " code_count"}, code_count, ncodes);
      chk({tag, " busy_at_done"}, busy, 0);
      chk({tag, " read_cycles"}, rd_q.size(), nbytes * RD_LAT);
      bad = 0;
      if (rd_q.size() == nbytes * RD_LAT)
         for (int k = 0; k < nbytes; k++)
            for (int j = 0; j < RD_LAT; j++)
               if (rd_q[k*RD_LAT + j] !== 16'(int'(a) + k)) bad++;
      chk({tag, " read_addrs"}, bad, 0);
      exp_q.delete();
      @(negedge clk);
      chk({tag, " done_one_cycle"}, done, 0);
   endtask

   // Sink: always ready, random ready, or ten stalled cycles per code.
   initial begin
      int stall_cnt;
      stall_cnt  = 0;
      code_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: code_ready = 1'b1;
            1: code_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (!code_valid) begin
                  stall_cnt  = 0;
                  code_ready = 1'b0;
               end else if (stall_cnt < 10) begin
                  stall_cnt++;
                  code_ready = 1'b0;
               end else begin
                  stall_cnt  = 0;
                  code_ready = 1'b1;
               end
            end
         endcase
      end
   end

   initial begin
      logic       held;
      logic [7:0] held_code;
      logic [7:0] want;
      held = 1'b0;
      held_code = 8'd0;
      forever begin
         @(negedge clk);
         if (RST) begin
            held = 1'b0;
         end else begin
            if (held) begin
               if (code_valid) chk("stall_hold", code_out, held_code);
               else begin
                  tests++; fails++;
                  $display("FAIL valid_drop: got code_valid 0 expected 1 (code %0h)", held_code);
               end
            end
            if (code_valid && code_ready) begin
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_code: got %0h expected none", code_out);
               end else begin
                  want = exp_q.pop_front();
                  chk("code", code_out, want);
               end
            end else if (code_valid) begin
               held = 1'b1;
               held_code = code_out;
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!RST && read_signal) rd_q.push_back(ramAddress);
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, nb, ncodes;
      logic [15:0] a;
      logic [2:0]  bp;
      bit          seen;
      RST = 1'b1; start = 1'b0; byteIndx = 16'd0; bitIndx = 3'd0; num_bits = 32'd0;
      #1;
      chk("reset_outputs", {ramAddress, read_signal, code_out, code_valid, busy, done, code_count},
          {16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0});
      repeat (3) @(posedge clk);
      #1 RST = 1'b0;

      mem[16'h0010] = 8'hF0;
      run_job(16'h0010, 3'd7, 8, 0, "c1");
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      run_job(16'h0000, 3'd7, 256, 0, "c2");
      mem[5] = 8'hA5;
      run_job(16'h0005, 3'd4, 5, 0, "c3");
      run_job(16'h0010, 3'd7, 8, 2, "c4_stall");
      run_job(16'h0000, 3'd7, 0, 0, "c5_zero");
      run_job(16'h0000, 3'd7, 127, 1, "run_max");
      run_job(16'h0000, 3'd7, 128, 1, "run_split");
      mem[16'hFFFF] = 8'h0F; mem[16'h0000] = 8'hFF;
      run_job(16'hFFFF, 3'd3, 12, 1, "addr_wrap");

      // Abandon a job while a code is waiting in EMIT.
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      ready_mode = 2;
      model(16'h0000, 7, 256, ncodes);
      @(posedge clk); #1;
      byteIndx = 16'h0000; bitIndx = 3'd7; num_bits = 256; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
         @(negedge clk);
         if (code_valid) seen = 1;
      end
      chk("c6 emit_reached", seen, 1);
      #1 RST = 1'b1;
      #1;
      chk("c6 async_reset", {ramAddress, read_signal, code_out, code_valid, busy, done, code_count},
          {16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0});
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1;
      RST = 1'b0;
      chk("c6 no_done_after_reset", done, 0);
      mem[16'h0010] = 8'hF0;
      run_job(16'h0010, 3'd7, 8, 0, "c6_restart");

      for (int t = 0; t < 20; t++) begin
         a  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
         bp = 3'($urandom_range(0, 7));
         n  = $urandom_range(1, 400);
         nb = ((7 - int'(bp)) + n + 7) / 8;
         for (int k = 0; k < nb; k++) begin
            case ($urandom_range(0, 2))
               0: mem[16'(int'(a) + k)] = 8'h00;
               1: mem[16'(int'(a) + k)] = 8'hFF;
               default: mem[16'(int'(a) + k)] = 8'($urandom);
            endcase
         end
         run_job(a, bp, n, $urandom_range(0, 1), "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
